// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_e : controller states (LOAD, RUN, DRAIN)
//   fetch_entry_t : one buffered instruction {pc, data}
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions toward decode.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the FIFO (wins over a same-cycle push)
//   push, push_data : write one entry
//   pop             : remove head (ignored when empty)
//   head            : entry at the head (registered storage)
//   count, empty    : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  // The issue rule upstream guarantees a free slot for every push.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !do_pop && count == CNT_DEPTH));
`endif

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory fetch controller.
// Owns the single instruction memory port: in LOAD the boot loader writes
// the program image; in RUN the controller issues sequential word reads
// and buffers the returned words toward decode; DRAIN is a one-cycle
// cleanup when the loader takes the memory back.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   boot_en                         : loader owns memory, fetch halted
//   ld_valid/ld_addr/ld_data/ld_ready : loader write channel
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata : memory port (1-cycle read)
//   redirect_valid/redirect_pc      : taken branch/jump
//   instr_valid/instr_pc/instr_data/instr_ready : decode handshake
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_en,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr_pc,
  output logic [31:0]       instr_data,
  input  logic              instr_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic             epoch;

  logic             rd_vld_p1;
  logic             rd_epoch_p1;
  logic [PC_W-1:0]  rd_pc_p1;

  logic             in_load;
  logic             in_run;
  logic             in_drain;
  logic             redirect;
  logic             issue;
  logic             pop;
  logic             push;
  logic             flush;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [CNT_W:0]   occupied;
  logic [CNT_W:0]   capacity;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             unused_redirect_lsb;

  assign in_load  = (state == LOAD);
  assign in_run   = (state == RUN);
  assign in_drain = (state == DRAIN);

  assign redirect    = in_run && redirect_valid;
  assign instr_valid = in_run && !fifo_empty && !redirect;
  assign pop         = instr_valid && instr_ready;

  // Slots already spoken for: buffered entries plus the read in flight.
  // A same-cycle pop frees one slot in time for the next push.
  assign occupied = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld_p1};
  assign capacity = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign issue    = in_run && !redirect && (occupied < capacity);

  // A response whose epoch predates the latest redirect is stale.
  assign push  = rd_vld_p1 && in_run && (rd_epoch_p1 == epoch);
  assign flush = redirect || in_drain;

  assign push_entry = '{pc: rd_pc_p1, data: mem_rdata};

  assign instr_pc   = instr_valid ? head.pc   : '0;
  assign instr_data = instr_valid ? head.data : '0;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      pc        <= RESET_PC;
      epoch     <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      case (state)
        LOAD: begin
          if (!boot_en) state <= RUN;
        end
        RUN: begin
          if (boot_en) state <= DRAIN;
          if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            epoch <= ~epoch;
          end else if (issue) begin
            pc <= pc + PC_STEP;
          end
        end
        DRAIN:   state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  // ---- p0 -> p1: read issued, remember which pc/epoch it belongs to ----
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_pc_p1    <= pc;
      rd_epoch_p1 <= epoch;
    end
  end

  always_comb begin
    ld_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (in_load) begin
      ld_ready = 1'b1;
      if (ld_valid) begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end
    end else if (issue) begin
      mem_req  = 1'b1;
      mem_addr = pc[ADDR_W+1:2];
    end
  end

  // ---- p1 -> p2: returned word enters the decode buffer ----
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

  localparam int          ADDR_W   = 8;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              boot_en;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              instr_valid;
  logic [31:0]       instr_pc;
  logic [31:0]       instr_data;
  logic              instr_ready;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .boot_en        (boot_en),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .instr_data     (instr_data),
    .instr_ready    (instr_ready)
  );

  // External memory (environment) and the reference image the bench expects.
  logic [31:0] ram [256];
  logic [31:0] img [256];

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;

  ent_t        exp_q [$];
  wr_t         wr_q  [$];
  ent_t        e;
  wr_t         w;
  int          total = 0;
  int          bad   = 0;
  int          wr_seen = 0;
  int          deliv = 0;
  bit          streaming = 0;
  logic [31:0] next_pc;
  logic [31:0] boot_words [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted instruction and every memory write is popped
  // from its expectation queue and compared.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr: got pc %0h data %0h, expected none", instr_pc, instr_data);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", 64'(instr_pc), 64'(e.pc));
        chk("instr_data", 64'(instr_data), 64'(e.data));
        deliv++;
      end
    end
    if (!reset && mem_req && mem_we) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected none", mem_addr, mem_wdata);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.addr));
        chk("wr_data", 64'(mem_wdata), 64'(w.data));
      end
    end
  end

  // Reference model: after a (re)start at pc P the decode side must see
  // P, P+4, P+8, ... with the image word at each pc, nothing else.
  task automatic top_up();
    while (streaming && exp_q.size() < 8) begin
      exp_q.push_back({next_pc, img[next_pc[9:2]]});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic start_stream(input logic [31:0] p);
    exp_q.delete();
    next_pc   = {p[31:2], 2'b00};
    streaming = 1'b1;
    top_up();
  endtask

  task automatic stop_stream();
    exp_q.delete();
    streaming = 1'b0;
  endtask

  task automatic ld_write(input logic [7:0] a, input logic [31:0] d);
    if ($urandom_range(0, 2) == 0) step();
    chk("ld_ready_load", 64'(ld_ready), 64'd1);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    img[a]   = d;
    wr_q.push_back({a, d});
    step();
    ld_valid = 1'b0;
  endtask

  // Counts cycles from the trigger cycle until instr_valid rises.
  task automatic lat(input string name, input int want);
    int n;
    #1;
    n = 0;
    while (!instr_valid && n < 10) begin
      step();
      redirect_valid = 1'b0;
      n++;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] t;
    int          reads;

    boot_words[0] = 32'h00a59513;
    boot_words[1] = 32'h00a51513;
    boot_words[2] = 32'h00a49513;
    boot_words[3] = 32'h00a41513;
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      img[i] = '0;
    end
    mem_rdata      = '0;
    reset          = 1'b1;
    boot_en        = 1'b1;
    ld_valid       = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Reset values
    repeat (3) step();
    chk("reset_ld_ready", 64'(ld_ready), 64'd1);
    chk("reset_instr_valid", 64'(instr_valid), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    reset = 1'b0;
    step();

    // Boot load of four words, then fetch from RESET_PC
    wr_seen = 0;
    for (int i = 0; i < 4; i++) ld_write(8'(i), boot_words[i]);
    instr_ready = 1'b1;
    boot_en     = 1'b0;
    start_stream(RESET_PC);
    lat("boot_latency", 3);
    repeat (10) step();
    chk("boot_write_cycles", 64'(wr_seen), 64'd4);
    chk("run_ld_ready", 64'(ld_ready), 64'd0);

    // Backpressure: buffer fills, reads stop, release resumes in order
    instr_ready = 1'b0;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 2 && mem_req) reads++;
    end
    chk("stall_no_reads", 64'(reads), 64'd0);
    chk("stall_valid", 64'(instr_valid), 64'd1);
    p = exp_q[0].pc;
    t = p + 32'(4 * DEPTH);
    instr_ready = 1'b1;
    #1;
    chk("release_issue", 64'(mem_req && !mem_we), 64'd1);
    chk("release_addr", 64'(mem_addr), 64'(t[9:2]));
    repeat (8) step();

    // Redirect with entries buffered
    instr_ready = 1'b0;
    repeat (4) step();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    start_stream(32'h0000_0042);
    lat("redirect_latency", 3);
    chk("redirect_first_pc", 64'(instr_pc), 64'h40);
    repeat (6) step();

    // Back-to-back redirects
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    start_stream(32'h0000_0020);
    step();
    redirect_pc = 32'h0000_0080;
    start_stream(32'h0000_0080);
    lat("b2b_latency", 3);
    chk("b2b_first_pc", 64'(instr_pc), 64'h80);
    repeat (6) step();

    // Reset in RUN with the buffer full
    instr_ready = 1'b0;
    repeat (5) step();
    chk("full_before_reset", 64'(instr_valid), 64'd1);
    reset   = 1'b1;
    boot_en = 1'b1;
    stop_stream();
    step();
    reset = 1'b0;
    chk("midrun_reset_ld_ready", 64'(ld_ready), 64'd1);
    chk("midrun_reset_instr_valid", 64'(instr_valid), 64'd0);
    chk("midrun_reset_mem_req", 64'(mem_req), 64'd0);
    step();
    boot_en     = 1'b0;
    instr_ready = 1'b1;
    start_stream(RESET_PC);
    lat("reset_restart_latency", 3);
    chk("reset_restart_pc", 64'(instr_pc), 64'(RESET_PC));
    repeat (6) step();

    // Re-enter boot with a read in flight
    boot_en = 1'b1;
    #1;
    chk("reentry_read_inflight", 64'(mem_req && !mem_we), 64'd1);
    step();
    stop_stream();
    chk("drain_ld_ready", 64'(ld_ready), 64'd0);
    chk("drain_mem_req", 64'(mem_req), 64'd0);
    chk("drain_instr_valid", 64'(instr_valid), 64'd0);
    step();
    ld_write(8'h10, $urandom);
    ld_write(8'h11, $urandom);
    boot_en = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    start_stream(32'h0000_0040);
    lat("reentry_latency", 3);
    repeat (6) step();

    // Redirect and boot_en together, then a full random image
    repeat (3) step();
    boot_en        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    stop_stream();
    step();
    redirect_valid = 1'b0;
    chk("simul_drain_ld_ready", 64'(ld_ready), 64'd0);
    step();
    for (int i = 0; i < 256; i++) ld_write(8'(i), $urandom);
    boot_en = 1'b0;
    start_stream(32'h0000_0100);
    lat("simul_latency", 3);
    chk("simul_first_pc", 64'(instr_pc), 64'h100);

    // Random traffic with random redirects and stray loader requests
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      ld_valid    = $urandom_range(0, 1) == 1;
      ld_addr     = 8'($urandom);
      ld_data     = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                           t = 32'($urandom_range(0, 1023));
        redirect_valid = 1'b1;
        redirect_pc    = t;
        start_stream(t);
      end
      step();
      redirect_valid = 1'b0;
      if (i % 50 == 0) chk("random_ld_ready", 64'(ld_ready), 64'd0);
    end
    ld_valid    = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();
    chk("random_progress", 64'(deliv > 300), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
